// File: rtl/axi_lite_sram_pkg.sv
// Shared AXI-lite definitions for the axi_lite_sram responder.
// Contents: bus width defaults, AXI response codes and a small helper that
// maps an address-decode result to the matching response code.
package axi_lite_sram_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_RESP_W = 2;

    localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

    // In-range accesses complete with OKAY, anything else decodes to nothing.
    function automatic logic [AXI_RESP_W-1:0] resp_for(input logic in_range);
        return in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
    endfunction

endpackage

// File: rtl/axi_lite_sram_sram_be.sv
// sram_be: synchronous DEPTH_WORDS x DATA_W memory.
// Ports:
//   clk      - rising-edge clock
//   rd_en    - capture mem[rd_idx] into the registered read port
//   rd_idx   - read word index
//   rd_data  - registered read data; holds its value while rd_en is low
//   wr_en    - commit enabled bytes of wr_data into mem[wr_idx]
//   wr_idx   - write word index
//   wr_strb  - per-byte write enables
//   wr_data  - write data
// A read and a write to the same word on the same edge return the old word.
module sram_be #(
    parameter int DEPTH_WORDS = 4096,
    parameter int DATA_W      = 32,
    localparam int IDX_W      = $clog2(DEPTH_WORDS),
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_idx];
        end
    end

    // Non-blocking update of mem gives read-before-write on a same-word collision.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_sram.sv
// axi_lite_sram: AXI-lite responder backed by a byte-writable word SRAM.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   araddr/arvalid/arready          - read address channel
//   rdata/rresp/rvalid/rready       - read data channel
//   awaddr/awvalid/awready          - write address channel
//   wdata/wstrb/wvalid/wready       - write data channel
//   bresp/bvalid/bready             - write response channel
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a raised valid output stays high with stable payload until that
// transfer (only reset can drop it), and inputs are ignored while ready is low.
// One read and one write may be outstanding at a time, independently.
// An AR handshake on edge T gives rvalid after edge T+RD_LATENCY; holding both
// AW and W from edge T gives bvalid after edge T+WR_LATENCY.
module axi_lite_sram
    import axi_lite_sram_pkg::*;
#(
    parameter int                ADDR_W      = AXI_ADDR_W,
    parameter int                DATA_W      = AXI_DATA_W,
    parameter int                DEPTH_WORDS = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                RD_LATENCY  = 1,
    parameter int                WR_LATENCY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_W-1:0]     rdata,
    output logic [AXI_RESP_W-1:0] rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [ADDR_W-1:0]     awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [AXI_RESP_W-1:0] bresp,
    output logic                  bvalid,
    input  logic                  bready
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(RD_LATENCY + WR_LATENCY + 1);
    localparam logic [63:0] SPAN_BYTES = 64'(DEPTH_WORDS) * 64'(STRB_W);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    // Offset is taken after the lower-bound test so a wrapped subtraction
    // below BASE_ADDR can never look in range.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (64'(off) < SPAN_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    // ---------------- read channel ----------------
    r_state_e              r_state_q, r_state_d;
    logic [CNT_W-1:0]      r_cnt_q, r_cnt_d;
    logic [ADDR_W-1:0]     r_addr_q, r_addr_d;
    logic                  r_ok_q, r_ok_d;
    logic [AXI_RESP_W-1:0] rresp_q, rresp_d;
    logic                  rd_en;
    logic [DATA_W-1:0]     sram_rdata;

    assign arready = !rst && (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_RESP);
    assign rresp   = rresp_q;
    // Out-of-range reads return zero; the array output is left untouched.
    assign rdata   = (rvalid && r_ok_q) ? sram_rdata : '0;

    // The handshake edge always lands in R_WAIT, so the SRAM capture and the
    // move to R_RESP happen RD_LATENCY edges after the AR handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_addr_d  = r_addr_q;
        r_ok_d    = r_ok_q;
        rresp_d   = rresp_q;
        rd_en     = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_addr_d  = araddr;
                    r_cnt_d   = CNT_W'(RD_LATENCY - 1);
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    rd_en     = in_range(r_addr_q);
                    r_ok_d    = in_range(r_addr_q);
                    rresp_d   = resp_for(in_range(r_addr_q));
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_addr_q  <= '0;
            r_ok_q    <= 1'b0;
            rresp_q   <= AXI_RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_addr_q  <= r_addr_d;
            r_ok_q    <= r_ok_d;
            rresp_q   <= rresp_d;
        end
    end

    // ---------------- write channel ----------------
    w_state_e              w_state_q, w_state_d;
    logic [CNT_W-1:0]      w_cnt_q, w_cnt_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_W-1:0]     aw_addr_q, aw_addr_d;
    logic [DATA_W-1:0]     w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic [AXI_RESP_W-1:0] bresp_q, bresp_d;
    logic                  wr_en;

    assign awready = !rst && (w_state_q == W_IDLE) && !aw_held_q;
    assign wready  = !rst && (w_state_q == W_IDLE) && !w_held_q;
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = bresp_q;

    // The commit fires only on the single W_WAIT cycle with cnt==0, which
    // is left immediately, so a write can never be applied twice.
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_addr_d = aw_addr_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        wr_en     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready) begin
                    aw_addr_d = awaddr;
                    aw_held_d = 1'b1;
                end
                if (wvalid && wready) begin
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                    w_held_d = 1'b1;
                end
                if (aw_held_d && w_held_d) begin
                    w_cnt_d   = CNT_W'(WR_LATENCY - 1);
                    w_state_d = W_WAIT;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) begin
                    wr_en     = in_range(aw_addr_q);
                    bresp_d   = resp_for(in_range(aw_addr_q));
                    w_state_d = W_RESP;
                end else begin
                    w_cnt_d = w_cnt_q - 1'b1;
                end
            end
            W_RESP: begin
                if (bready) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_addr_q <= aw_addr_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
        end
    end

    sram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_sram (
        .clk     (clk),
        .rd_en   (rd_en),
        .rd_idx  (to_idx(r_addr_q)),
        .rd_data (sram_rdata),
        .wr_en   (wr_en),
        .wr_idx  (to_idx(aw_addr_q)),
        .wr_strb (w_strb_q),
        .wr_data (w_data_q)
    );

endmodule
